// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output stage: FSM states, FIFO depth
// and default widths.
package fir_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fsm_state_e;

    localparam int FIFO_DEPTH     = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 25;
    localparam int DEF_FRAC_BITS  = 12;
    localparam int DEF_CNT_WIDTH  = 12;

endpackage

// File: rtl/fir_out_stage_if.sv
// Pixel output stream of the FIR output stage: valid/ready handshake plus
// data and frame/line markers.
interface fir_out_stage_if
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  sof_o;
    logic                  eol_o;

    modport master (output valid_o, data_o, sof_o, eol_o, input ready_i);
    modport slave  (input valid_o, data_o, sof_o, eol_o, output ready_i);

endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write to a full FIFO is accepted
// only when a read happens in the same cycle. DEPTH must be a power of two.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ack_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_ack_o  = wr_ok;

    always_comb begin
        rd_ok    = rd_en_i && !empty_o;
        wr_ok    = wr_en_i && (!full_o || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: register, round/shift, clamp, queue and stream pixels with
// frame position markers. Define FIR_OUT_ROUND_EN for round-half-up, else truncate.
module fir_out_stage
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce_i,
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic        [CNT_WIDTH-1:0] h_size_i,
    input  logic        [CNT_WIDTH-1:0] v_size_i,
    fir_out_stage_if.master             out_if,
    output logic                        afull_o,
    output logic                        ovf_o,
    output logic                        sat_o,
    output logic                        frame_done_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [ACC_WIDTH:0] PIX_MAX =
        $signed({{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});
`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND_C =
        $signed({{(ACC_WIDTH + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}});
`else
    localparam logic signed [ACC_WIDTH:0] RND_C = '0;
`endif

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        s1_vld_q, s1_vld_d;
    logic [CNT_WIDTH-1:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_WIDTH-1:0]        h_size_q, h_size_d, v_size_q, v_size_d;
    logic                        sat_q, sat_d, ovf_q, ovf_d;
    fsm_state_e                  state_q, state_d;

    logic signed [ACC_WIDTH:0]   sum, shifted;
    logic [DATA_WIDTH-1:0]       pix, rd_data;
    logic                        clamp, wr_ack, full, empty, xfer, h_last, v_last;
    logic [CW-1:0]               count;

    fir_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (s1_vld_q),
        .wr_data_i (pix),
        .wr_ack_o  (wr_ack),
        .rd_en_i   (xfer),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count)
    );

    assign xfer           = !empty && out_if.ready_i;
    assign h_last         = (h_cnt_q == h_size_q - CNT_WIDTH'(1));
    assign v_last         = (v_cnt_q == v_size_q - CNT_WIDTH'(1));
    assign out_if.valid_o = !empty;
    assign out_if.data_o  = empty ? '0 : rd_data;
    assign out_if.sof_o   = !empty && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign out_if.eol_o   = !empty && h_last;
    assign frame_done_o   = xfer && h_last && v_last;
    assign afull_o        = (count >= CW'(2));
    assign ovf_o          = ovf_q;
    assign sat_o          = sat_q;

    // The extra sign bit keeps the rounding add from overflowing before the shift.
    always_comb begin
        sum     = $signed({acc_q[ACC_WIDTH-1], acc_q}) + RND_C;
        shifted = sum >>> FRAC_BITS;
        clamp   = 1'b0;
        pix     = shifted[DATA_WIDTH-1:0];
        if (shifted[ACC_WIDTH]) begin
            pix   = '0;
            clamp = 1'b1;
        end else if (shifted > PIX_MAX) begin
            pix   = '1;
            clamp = 1'b1;
        end
    end

    always_comb begin
        acc_d    = ce_i ? acc_i : acc_q;
        s1_vld_d = ce_i;
        sat_d    = sat_q || (s1_vld_q && clamp);
        ovf_d    = ovf_q || (s1_vld_q && !wr_ack);
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_size_d = h_size_q;
        v_size_d = v_size_q;
        state_d  = state_q;

        if (xfer) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CNT_WIDTH'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_WIDTH'(1);
            end
        end

        // Frame geometry is frozen for the whole ACTIVE period.
        case (state_q)
            ST_IDLE: begin
                h_size_d = (h_size_i == '0) ? CNT_WIDTH'(1) : h_size_i;
                v_size_d = (v_size_i == '0) ? CNT_WIDTH'(1) : v_size_i;
                if (wr_ack) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: if (frame_done_o) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            s1_vld_q <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_size_q <= CNT_WIDTH'(1);
            v_size_q <= CNT_WIDTH'(1);
            state_q  <= ST_IDLE;
        end else begin
            acc_q    <= acc_d;
            s1_vld_q <= s1_vld_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_size_q <= h_size_d;
            v_size_q <= v_size_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage; rounding expectations follow FIR_OUT_ROUND_EN.
module tb_fir_out_stage;

    // 26-bit accumulator so that 0x1000000 is a positive overflow value.
    localparam int AW = 26;
    localparam int DW = 8;
    localparam int FB = 12;
    localparam int CW = 12;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ce_i = 1'b0;
    logic signed [AW-1:0] acc_i = '0;
    logic [CW-1:0]        h_size_i = 12'd4;
    logic [CW-1:0]        v_size_i = 12'd2;
    logic                 afull_o, ovf_o, sat_o, frame_done_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got_data [16];
    logic          got_sof  [16];
    logic          got_eol  [16];
    logic          got_fd   [16];
    int            got_n;

    fir_out_stage_if #(.DATA_WIDTH(DW)) out_if ();

    fir_out_stage #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .FRAC_BITS  (FB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce_i         (ce_i),
        .acc_i        (acc_i),
        .h_size_i     (h_size_i),
        .v_size_i     (v_size_i),
        .out_if       (out_if.master),
        .afull_o      (afull_o),
        .ovf_o        (ovf_o),
        .sat_o        (sat_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n          = 1'b0;
        ce_i           = 1'b0;
        out_if.ready_i = 1'b0;
        h_size_i       = 12'd4;
        v_size_i       = 12'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_ce(input logic signed [AW-1:0] v);
        ce_i  = 1'b1;
        acc_i = v;
        @(negedge clk);
        ce_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_if.valid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: valid_o never rose, required 1 within 10 cycles", name);
        end
    endtask

    task automatic pop();
        out_if.ready_i = 1'b1;
        @(negedge clk);
        out_if.ready_i = 1'b0;
    endtask

    // Pushes n back-to-back values (base+i as pixel) with ready high and records every transfer.
    task automatic stream(input int n, input int base);
        got_n          = 0;
        out_if.ready_i = 1'b1;
        for (int c = 0; c < n + 8; c++) begin
            if (out_if.valid_o === 1'b1 && got_n < 16) begin
                got_data[got_n] = out_if.data_o;
                got_sof[got_n]  = out_if.sof_o;
                got_eol[got_n]  = out_if.eol_o;
                got_fd[got_n]   = frame_done_o;
                got_n++;
            end
            ce_i  = (c < n);
            acc_i = AW'((base + c) * 4096);
            @(negedge clk);
        end
        ce_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({out_if.valid_o, out_if.sof_o, out_if.eol_o, afull_o, ovf_o, sat_o, frame_done_o} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b%b, required 0000000", out_if.valid_o,
                     out_if.sof_o, out_if.eol_o, afull_o, ovf_o, sat_o, frame_done_o);
        end
        total++;
        if (out_if.data_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_data: data_o=%0d, required 0", out_if.data_o);
        end
    endtask

    task automatic test_rounding();
        logic [DW-1:0] exp_v;
`ifdef FIR_OUT_ROUND_EN
        exp_v = 8'd2;
`else
        exp_v = 8'd1;
`endif
        do_reset();
        drive_ce(AW'(32'h1800));
        total++;
        if (out_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL latency: valid_o=%b one cycle after ce_i, required 0", out_if.valid_o);
        end
        wait_valid("round");
        total++;
        if (out_if.data_o !== exp_v) begin
            bad++;
            $display("FAIL round_data: data_o=%0d, required %0d", out_if.data_o, exp_v);
        end
        total++;
        if (sat_o !== 1'b0) begin
            bad++;
            $display("FAIL round_sat: sat_o=%b, required 0", sat_o);
        end
        pop();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_ce(-AW'(4096));
        wait_valid("sat_lo");
        total++;
        if (out_if.data_o !== 8'd0 || sat_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_low: data_o=%0d sat_o=%b, required 0 and 1", out_if.data_o, sat_o);
        end
        do_reset();
        drive_ce(AW'(32'h1000000));
        wait_valid("sat_hi");
        total++;
        if (out_if.data_o !== 8'd255 || sat_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_high: data_o=%0d sat_o=%b, required 255 and 1", out_if.data_o, sat_o);
        end
    endtask

    task automatic test_frame();
        do_reset();
        stream(8, 0);
        total++;
        if (got_n !== 8) begin
            bad++;
            $display("FAIL frame_count: transfers=%0d, required 8", got_n);
        end
        for (int i = 0; i < 8 && i < got_n; i++) begin
            total++;
            if (got_data[i] !== DW'(i) || got_sof[i] !== (i == 0) ||
                got_eol[i] !== (i == 3 || i == 7) || got_fd[i] !== (i == 7)) begin
                bad++;
                $display("FAIL frame_px%0d: data=%0d sof=%b eol=%b fd=%b, required %0d %b %b %b", i,
                         got_data[i], got_sof[i], got_eol[i], got_fd[i], i, (i == 0),
                         (i == 3 || i == 7), (i == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ce_i  = 1'b1;
            acc_i = AW'((10 + i) * 4096);
            @(negedge clk);
        end
        ce_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (afull_o !== 1'b1 || ovf_o !== 1'b1 || out_if.valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_flags: afull=%b ovf=%b valid=%b, required 1 1 1", afull_o, ovf_o,
                     out_if.valid_o);
        end
        total++;
        if (out_if.data_o !== 8'd10) begin
            bad++;
            $display("FAIL bp_hold: data_o=%0d while stalled, required 10", out_if.data_o);
        end
        out_if.ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_if.valid_o === 1'b1) begin
                total++;
                if (out_if.data_o !== DW'(10 + n)) begin
                    bad++;
                    $display("FAIL bp_order%0d: data_o=%0d, required %0d", n, out_if.data_o, 10 + n);
                end
                n++;
            end
            @(negedge clk);
        end
        out_if.ready_i = 1'b0;
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL bp_kept: delivered=%0d, required 4", n);
        end
    endtask

    task automatic test_size_shadow();
        do_reset();
        stream(1, 0);
        h_size_i = 12'd2;
        stream(7, 1);
        total++;
        if (got_n !== 7 || got_eol[2] !== 1'b1 || got_eol[1] !== 1'b0 || got_fd[6] !== 1'b1) begin
            bad++;
            $display("FAIL shadow_active: n=%0d eol1=%b eol2=%b fd6=%b, required 7 0 1 1", got_n,
                     got_eol[1], got_eol[2], got_fd[6]);
        end
        stream(2, 8);
        total++;
        if (got_n !== 2 || got_sof[0] !== 1'b1 || got_eol[1] !== 1'b1) begin
            bad++;
            $display("FAIL shadow_idle: n=%0d sof0=%b eol1=%b, required 2 1 1", got_n, got_sof[0],
                     got_eol[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ce_i  = 1'b1;
            acc_i = AW'((5 + i) * 4096);
            @(negedge clk);
        end
        ce_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (afull_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_queued: afull_o=%b with 3 entries, required 1", afull_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (out_if.valid_o !== 1'b0 || afull_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid_o=%b afull_o=%b, required 0 0", out_if.valid_o, afull_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        stream(2, 20);
        total++;
        if (got_n !== 2 || got_sof[0] !== 1'b1 || got_data[0] !== 8'd20) begin
            bad++;
            $display("FAIL mid_sof: n=%0d sof=%b data=%0d, required 2 1 20", got_n, got_sof[0],
                     got_data[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_if.ready_i = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_frame();
        test_back_to_back();
        test_size_shadow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
